// File: rtl/selen_fetch_pkg.sv
// Shared types and constants for the Wishbone instruction prefetch master.
//   fetch_entry_t : one prefetched word as held in the FIFO {pc, instr, err}
//   issue_state_e : strobe issue state (idle / strobing this cycle)
//   WORD_BYTES    : address increment per fetched word
//   SEL_ALL       : byte-select value for full-word reads
package selen_fetch_pkg;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] SEL_ALL    = 4'hF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STROBE = 1'b1
    } issue_state_e;

endpackage

// File: rtl/wb_fetch_fifo.sv
// Small synchronous FIFO of fetch_entry_t used as the prefetch buffer.
// Ports:
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   flush_i            : empties the FIFO; a push or pop in the same cycle is ignored
//   push_i/push_data_i : write an entry (caller guarantees space)
//   pop_i              : remove the head when valid
//   head_o, valid_o    : current head entry and its valid flag
//   count_o            : number of stored entries
module wb_fetch_fifo
    import selen_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push, do_pop;

    assign valid_o = (count_reg != '0);
    assign count_o = count_reg;
    assign head_o  = mem[rd_ptr_reg];
    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & valid_o & ~flush_i;

    // Storage has no reset: only entries below count_reg are ever observed.
    always_ff @(posedge wb_clk_i) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/wb_fetch_master.sv
// Wishbone read master that prefetches 32-bit instruction words into a FIFO
// for the fetch stage. Issues single-cycle pipelined strobes (1 word/clk),
// tracks outstanding requests, and on redirect flushes the FIFO and discards
// every response still in flight.
// Ports:
//   wb_clk_i, wb_rst_i           : clock, asynchronous active-high reset
//   wb_adr_o/dat_o/sel_o/we_o    : request address (read-only, full word)
//   wb_cyc_o, wb_stb_o           : bus cycle and one-cycle strobe
//   wb_dat_i, wb_ack_i, wb_err_i : in-order responses
//   fetch_en_i                   : allow new requests
//   redir_i, redir_pc_i          : flush and restart at redir_pc_i
//   instr_valid_o/ready_i        : FIFO head handshake
//   instr_o, instr_pc_o, instr_err_o : head word, its address, error flag
//   proto_err_o                  : sticky, response seen with nothing outstanding
module wb_fetch_master
    import selen_fetch_pkg::*;
#(
    parameter int            AW         = 32,
    parameter int            DW         = 32,
    parameter int            FIFO_DEPTH = 4,
    parameter int            MAX_OUTST  = 2,
    parameter logic [AW-1:0] RESET_PC   = '0
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    input  logic [DW-1:0] wb_dat_i,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          fetch_en_i,
    input  logic          redir_i,
    input  logic [AW-1:0] redir_pc_i,
    output logic          instr_valid_o,
    input  logic          instr_ready_i,
    output logic [DW-1:0] instr_o,
    output logic [AW-1:0] instr_pc_o,
    output logic          instr_err_o,
    output logic          proto_err_o
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    issue_state_e  state_reg, state_next;
    logic [AW-1:0] adr_reg, adr_next, pc_reg, pc_next;
    logic [OW-1:0] outst_reg, outst_next, drop_reg, drop_next;
    logic          proto_err_reg, proto_err_next;
    logic [QW-1:0] q_wr_reg, q_rd_reg;
    logic [AW-1:0] pcq_mem [MAX_OUTST];
    logic          resp, resp_ok, stray, fifo_push, fifo_pop, can_issue;
    logic [CW-1:0] fifo_cnt;
    fetch_entry_t  fifo_in, fifo_head;
    int            outst_nx, fifo_cnt_nx;
    logic [1:0]    unused_pc_bits;

    assign unused_pc_bits = redir_pc_i[1:0];

    assign wb_stb_o    = (state_reg == ST_STROBE);
    assign wb_cyc_o    = wb_stb_o | (outst_reg != '0);
    assign wb_adr_o    = adr_reg;
    assign wb_dat_o    = '0;
    assign wb_sel_o    = SEL_ALL;
    assign wb_we_o     = 1'b0;
    assign proto_err_o = proto_err_reg;

    // A response only counts when something is actually outstanding.
    assign resp      = wb_ack_i | wb_err_i;
    assign resp_ok   = resp & (outst_reg != '0);
    assign stray     = resp & (outst_reg == '0);
    assign fifo_push = resp_ok & (drop_reg == '0) & ~redir_i;
    assign fifo_pop  = instr_valid_o & instr_ready_i;

    function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
        return (p == QW'(MAX_OUTST - 1)) ? '0 : p + QW'(1);
    endfunction

    // Credits are checked against the state after this cycle's events, so a
    // strobe issued now can never overflow the FIFO when its word lands.
    always_comb begin
        outst_nx       = int'(outst_reg) + int'(wb_stb_o) - int'(resp_ok);
        fifo_cnt_nx    = redir_i ? 0 : int'(fifo_cnt) + int'(fifo_push) - int'(fifo_pop);
        can_issue      = fetch_en_i && !redir_i && (outst_nx < MAX_OUTST)
                         && ((outst_nx + fifo_cnt_nx) < FIFO_DEPTH);
        state_next     = can_issue ? ST_STROBE : ST_IDLE;
        adr_next       = adr_reg;
        pc_next        = pc_reg;
        drop_next      = drop_reg;
        outst_next     = OW'(outst_nx);
        proto_err_next = proto_err_reg | stray;
        if (redir_i) begin
            // Everything still on the bus after this cycle must be discarded,
            // including a strobe issued in this very cycle.
            pc_next   = {redir_pc_i[AW-1:2], 2'b00};
            drop_next = OW'(outst_nx);
        end else begin
            if (can_issue) begin
                adr_next = pc_reg;
                pc_next  = pc_reg + AW'(WORD_BYTES);
            end
            if (resp_ok && drop_reg != '0) begin
                drop_next = drop_reg - OW'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg     <= ST_IDLE;
            adr_reg       <= RESET_PC;
            pc_reg        <= RESET_PC;
            outst_reg     <= '0;
            drop_reg      <= '0;
            proto_err_reg <= 1'b0;
            q_wr_reg      <= '0;
            q_rd_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            adr_reg       <= adr_next;
            pc_reg        <= pc_next;
            outst_reg     <= outst_next;
            drop_reg      <= drop_next;
            proto_err_reg <= proto_err_next;
            if (wb_stb_o) q_wr_reg <= q_inc(q_wr_reg);
            if (resp_ok)  q_rd_reg <= q_inc(q_rd_reg);
        end
    end

    // In-order address queue: dropped responses still pop their entry, so
    // the queue stays aligned with the bus across redirects.
    always_ff @(posedge wb_clk_i) begin
        if (wb_stb_o) begin
            pcq_mem[q_wr_reg] <= adr_reg;
        end
    end

    assign fifo_in = '{pc: 32'(pcq_mem[q_rd_reg]), instr: 32'(wb_dat_i), err: wb_err_i};

    wb_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .flush_i     (redir_i),
        .push_i      (fifo_push),
        .push_data_i (fifo_in),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .valid_o     (instr_valid_o),
        .count_o     (fifo_cnt)
    );

    assign instr_o     = fifo_head.instr[DW-1:0];
    assign instr_pc_o  = fifo_head.pc[AW-1:0];
    assign instr_err_o = fifo_head.err;

endmodule
